mem_responder: RTL and testbench

- Multicycle memory target on the far side of the control unit's memory-request signals.
- Accepts one read or write request at a time.
- Inserts a configurable number of wait states, then returns a one-cycle MemReady completion with read data or an address error.
- Lets the control unit's FSM hold in a memory-wait state instead of assuming single-cycle memory.

---
 rtl/mem_responder_if.sv | 13 +
 rtl/mem_responder.sv | 71 +++++++
 tb/tb_mem_responder.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/mem_responder_if.sv
// mem_responder_if: request/response signals between the control unit and the memory target
interface mem_responder_if;
  logic        MemRead;
  logic        MemWrite;
  logic [31:0] Address;
  logic [31:0] WriteData;
  logic [31:0] ReadData;
  logic        MemReady;
  logic        AddrError;
  logic        Busy;
  modport master (output MemRead, MemWrite, Address, WriteData, input ReadData, MemReady, AddrError, Busy);
  modport slave  (input MemRead, MemWrite, Address, WriteData, output ReadData, MemReady, AddrError, Busy);
endinterface

// File: rtl/mem_responder.sv
// mem_responder: multicycle word memory with programmable wait states and a one-cycle completion pulse
module mem_responder #(
  parameter int DEPTH_WORDS = 64,
  parameter int WAIT_CYCLES = 2
) (
  input logic            Clk,
  input logic            Reset_PC,
  mem_responder_if.slave bus
);
  localparam int AW = DEPTH_WORDS > 1 ? $clog2(DEPTH_WORDS) : 1;
  localparam int CW = WAIT_CYCLES > 1 ? $clog2(WAIT_CYCLES) : 1;
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
  state_t        r_state, w_next;
  logic [CW-1:0] r_cnt;
  logic [31:0]   r_addr, r_wdata, r_rdata;
  logic          r_we, r_err;
  logic [31:0]   mem [DEPTH_WORDS];
  logic          w_req, w_accept, w_we, w_err, w_to_resp;
  logic [31:0]   w_addr;
  logic [AW-1:0] w_idx;
  assign w_req     = bus.MemRead | bus.MemWrite;
  assign w_accept  = (r_state == IDLE) & w_req;
  // with zero wait states the response is computed straight from the live request
  assign w_addr    = (r_state == IDLE) ? bus.Address : r_addr;
  assign w_we      = (r_state == IDLE) ? bus.MemWrite : r_we;
  assign w_err     = (|w_addr[1:0]) | ({2'b00, w_addr[31:2]} >= 32'(DEPTH_WORDS));
  assign w_idx     = w_addr[AW+1:2];
  assign w_to_resp = (w_next == RESP) & (r_state != RESP);
  // state register
  always_ff @(posedge Clk or negedge Reset_PC)
    if (!Reset_PC) r_state <= IDLE;
    else           r_state <= w_next;
  // next-state decode
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    w_next = w_req ? ((WAIT_CYCLES == 0) ? RESP : WAIT) : IDLE;
      WAIT:    w_next = (r_cnt == '0) ? RESP : WAIT;
      RESP:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end
  // latch the request once at acceptance; later input changes are ignored until the next IDLE
  always_ff @(posedge Clk or negedge Reset_PC)
    if (!Reset_PC) begin
      r_addr  <= '0;
      r_wdata <= '0;
      r_we    <= 1'b0;
      r_err   <= 1'b0;
      r_cnt   <= '0;
    end else if (w_accept) begin
      r_addr  <= bus.Address;
      r_wdata <= bus.WriteData;
      r_we    <= bus.MemWrite;
      r_err   <= w_err;
      r_cnt   <= CW'(WAIT_CYCLES - 1);
    end else if (r_state == WAIT) begin
      r_cnt   <= r_cnt - 1'b1;
    end
  // read result is loaded on the edge entering RESP so it is valid alongside MemReady
  always_ff @(posedge Clk or negedge Reset_PC)
    if (!Reset_PC)      r_rdata <= '0;
    else if (w_to_resp) r_rdata <= w_err ? '0 : (w_we ? r_rdata : mem[w_idx]);
  // array write commits on the edge leaving RESP, so a reset during WAIT drops it
  always_ff @(posedge Clk)
    if ((r_state == RESP) && r_we && !r_err) mem[r_addr[AW+1:2]] <= r_wdata;
  assign bus.ReadData  = r_rdata;
  assign bus.MemReady  = (r_state == RESP);
  assign bus.AddrError = (r_state == RESP) & r_err;
  assign bus.Busy      = (r_state != IDLE);
endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder: directed checks of latency, errors, ignore-while-busy, async reset and zero-wait mode
module tb_mem_responder;
  logic Clk = 1'b0;
  logic Reset_PC = 1'b0;
  int   n_cmp = 0;
  int   n_err = 0;
  mem_responder_if bus2 ();
  mem_responder_if bus0 ();
  mem_responder #(.DEPTH_WORDS(64), .WAIT_CYCLES(2)) dut2 (.Clk(Clk), .Reset_PC(Reset_PC), .bus(bus2.slave));
  mem_responder #(.DEPTH_WORDS(64), .WAIT_CYCLES(0)) dut0 (.Clk(Clk), .Reset_PC(Reset_PC), .bus(bus0.slave));
  always #5 Clk = ~Clk;

  task automatic run_txn(input bit sel, input logic we, input logic re, input logic [31:0] addr, input logic [31:0] data,
                         output int lat, output int pulses, output logic err, output logic [31:0] rd);
    @(negedge Clk);
    if (sel) begin bus0.MemWrite = we; bus0.MemRead = re; bus0.Address = addr; bus0.WriteData = data; end
    else     begin bus2.MemWrite = we; bus2.MemRead = re; bus2.Address = addr; bus2.WriteData = data; end
    @(posedge Clk);
    #1;
    bus0.MemWrite = 1'b0; bus0.MemRead = 1'b0; bus2.MemWrite = 1'b0; bus2.MemRead = 1'b0;
    lat = -1; pulses = 0; err = 1'bx; rd = 'x;
    for (int c = 1; c <= 6; c++) begin
      @(negedge Clk);
      if (sel ? bus0.MemReady : bus2.MemReady) begin
        pulses++;
        if (lat < 0) begin
          lat = c;
          err = sel ? bus0.AddrError : bus2.AddrError;
          rd  = sel ? bus0.ReadData : bus2.ReadData;
        end
      end
    end
  endtask

  task automatic test_reset;
    bus2.MemRead = 0; bus2.MemWrite = 0; bus2.Address = 0; bus2.WriteData = 0;
    bus0.MemRead = 0; bus0.MemWrite = 0; bus0.Address = 0; bus0.WriteData = 0;
    repeat (2) @(negedge Clk);
    n_cmp++; if ({bus2.MemReady, bus2.AddrError, bus2.Busy} !== 3'b000) begin n_err++; $display("FAIL reset_flags2: got %b want 000", {bus2.MemReady, bus2.AddrError, bus2.Busy}); end
    n_cmp++; if (bus2.ReadData !== 32'h0) begin n_err++; $display("FAIL reset_rdata2: got %h want 00000000", bus2.ReadData); end
    n_cmp++; if ({bus0.MemReady, bus0.AddrError, bus0.Busy} !== 3'b000) begin n_err++; $display("FAIL reset_flags0: got %b want 000", {bus0.MemReady, bus0.AddrError, bus0.Busy}); end
    Reset_PC = 1'b1;
  endtask

  task automatic test_preload;
    int lat, p; logic e; logic [31:0] rd;
    run_txn(0, 1, 0, 32'h0, 32'h11111111, lat, p, e, rd);
    n_cmp++; if (lat !== 3 || e !== 1'b0) begin n_err++; $display("FAIL preload0: lat %0d err %b want 3 0", lat, e); end
    run_txn(0, 1, 0, 32'h20, 32'h22222222, lat, p, e, rd);
    n_cmp++; if (lat !== 3 || e !== 1'b0) begin n_err++; $display("FAIL preload20: lat %0d err %b want 3 0", lat, e); end
    run_txn(0, 1, 0, 32'h04, 32'h44444444, lat, p, e, rd);
    n_cmp++; if (lat !== 3 || e !== 1'b0) begin n_err++; $display("FAIL preload04: lat %0d err %b want 3 0", lat, e); end
  endtask

  task automatic test_write_read;
    int lat, p; logic e; logic [31:0] rd;
    run_txn(0, 1, 0, 32'h10, 32'hDEADBEEF, lat, p, e, rd);
    n_cmp++; if (lat !== 3) begin n_err++; $display("FAIL wr_latency: got %0d want 3", lat); end
    n_cmp++; if (p !== 1 || e !== 1'b0) begin n_err++; $display("FAIL wr_pulse: pulses %0d err %b want 1 0", p, e); end
    run_txn(0, 0, 1, 32'h10, 32'h0, lat, p, e, rd);
    n_cmp++; if (lat !== 3 || rd !== 32'hDEADBEEF) begin n_err++; $display("FAIL rd_after_wr: lat %0d data %h want 3 deadbeef", lat, rd); end
  endtask

  task automatic test_misalign;
    int lat, p; logic e; logic [31:0] rd;
    run_txn(0, 0, 1, 32'h12, 32'h0, lat, p, e, rd);
    n_cmp++; if (lat !== 3 || e !== 1'b1 || rd !== 32'h0) begin n_err++; $display("FAIL misalign: lat %0d err %b data %h want 3 1 00000000", lat, e, rd); end
    run_txn(0, 0, 1, 32'h10, 32'h0, lat, p, e, rd);
    n_cmp++; if (e !== 1'b0 || rd !== 32'hDEADBEEF) begin n_err++; $display("FAIL misalign_after: err %b data %h want 0 deadbeef", e, rd); end
  endtask

  task automatic test_out_of_range;
    int lat, p; logic e; logic [31:0] rd;
    run_txn(0, 1, 0, 32'h100, 32'h12345678, lat, p, e, rd);
    n_cmp++; if (lat !== 3 || e !== 1'b1 || rd !== 32'h0) begin n_err++; $display("FAIL oor_write: lat %0d err %b data %h want 3 1 00000000", lat, e, rd); end
    run_txn(0, 0, 1, 32'h0, 32'h0, lat, p, e, rd);
    n_cmp++; if (e !== 1'b0 || rd !== 32'h11111111) begin n_err++; $display("FAIL oor_no_wrap: err %b data %h want 0 11111111", e, rd); end
    run_txn(0, 0, 1, 32'h80000010, 32'h0, lat, p, e, rd);
    n_cmp++; if (e !== 1'b1 || rd !== 32'h0) begin n_err++; $display("FAIL oor_high: err %b data %h want 1 00000000", e, rd); end
  endtask

  task automatic test_write_keeps_rdata;
    int lat, p; logic e; logic [31:0] rd;
    run_txn(0, 0, 1, 32'h0, 32'h0, lat, p, e, rd);
    run_txn(0, 1, 0, 32'h24, 32'h99999999, lat, p, e, rd);
    n_cmp++; if (e !== 1'b0 || rd !== 32'h11111111) begin n_err++; $display("FAIL wr_keeps_rdata: err %b data %h want 0 11111111", e, rd); end
  endtask

  task automatic test_busy_ignore;
    int lat = -1, p = 0; logic busy; logic [31:0] rd = 'x;
    @(negedge Clk);
    bus2.MemRead = 1; bus2.Address = 32'h04;
    @(posedge Clk);
    #1;
    bus2.MemRead = 0; bus2.MemWrite = 1; bus2.Address = 32'h20; bus2.WriteData = 32'hAAAAAAAA;
    for (int c = 1; c <= 7; c++) begin
      @(negedge Clk);
      if (c == 1) busy = bus2.Busy;
      if (bus2.MemReady) begin p++; if (lat < 0) begin lat = c; rd = bus2.ReadData; end end
      bus2.MemWrite = (c == 2);
    end
    n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL busy_flag: got %b want 1", busy); end
    n_cmp++; if (p !== 1 || lat !== 3) begin n_err++; $display("FAIL busy_pulses: pulses %0d lat %0d want 1 3", p, lat); end
    n_cmp++; if (rd !== 32'h44444444) begin n_err++; $display("FAIL busy_orig: got %h want 44444444", rd); end
    begin
      int l2, p2; logic e2; logic [31:0] rd2;
      run_txn(0, 0, 1, 32'h20, 32'h0, l2, p2, e2, rd2);
      n_cmp++; if (rd2 !== 32'h22222222) begin n_err++; $display("FAIL busy_no_write: got %h want 22222222", rd2); end
    end
  endtask

  task automatic test_reset_mid_write;
    int lat, p; logic e; logic [31:0] rd;
    run_txn(0, 0, 1, 32'h10, 32'h0, lat, p, e, rd);
    @(negedge Clk);
    bus2.MemWrite = 1; bus2.Address = 32'h04; bus2.WriteData = 32'h55AA55AA;
    @(posedge Clk);
    #1 bus2.MemWrite = 0;
    @(negedge Clk);
    n_cmp++; if (bus2.Busy !== 1'b1) begin n_err++; $display("FAIL rst_pre_busy: got %b want 1", bus2.Busy); end
    #1 Reset_PC = 1'b0;
    #1;
    n_cmp++; if ({bus2.Busy, bus2.MemReady, bus2.AddrError} !== 3'b000 || bus2.ReadData !== 32'h0) begin n_err++; $display("FAIL rst_async: flags %b data %h want 000 00000000", {bus2.Busy, bus2.MemReady, bus2.AddrError}, bus2.ReadData); end
    repeat (2) @(negedge Clk);
    Reset_PC = 1'b1;
    run_txn(0, 0, 1, 32'h04, 32'h0, lat, p, e, rd);
    n_cmp++; if (lat !== 3 || rd !== 32'h44444444) begin n_err++; $display("FAIL rst_no_commit: lat %0d data %h want 3 44444444", lat, rd); end
  endtask

  task automatic test_wait0;
    int lat, p; logic e; logic [31:0] rd;
    run_txn(1, 1, 1, 32'h08, 32'h0000CAFE, lat, p, e, rd);
    n_cmp++; if (lat !== 1 || p !== 1 || e !== 1'b0) begin n_err++; $display("FAIL w0_write: lat %0d pulses %0d err %b want 1 1 0", lat, p, e); end
    run_txn(1, 0, 1, 32'h08, 32'h0, lat, p, e, rd);
    n_cmp++; if (lat !== 1 || rd !== 32'h0000CAFE) begin n_err++; $display("FAIL w0_read: lat %0d data %h want 1 0000cafe", lat, rd); end
    run_txn(1, 0, 1, 32'h09, 32'h0, lat, p, e, rd);
    n_cmp++; if (lat !== 1 || e !== 1'b1 || rd !== 32'h0) begin n_err++; $display("FAIL w0_misalign: lat %0d err %b data %h want 1 1 00000000", lat, e, rd); end
  endtask

  task automatic test_back_to_back;
    logic [8:0] seen = '0;
    @(negedge Clk);
    bus2.MemRead = 1; bus2.Address = 32'h10;
    @(posedge Clk);
    for (int c = 1; c <= 8; c++) begin
      @(negedge Clk);
      seen[c] = bus2.MemReady;
      if (c == 7) bus2.MemRead = 0;
    end
    n_cmp++; if (seen !== 9'b010001000) begin n_err++; $display("FAIL back_to_back: pulses %b want 010001000", seen); end
    n_cmp++; if (bus2.ReadData !== 32'hDEADBEEF) begin n_err++; $display("FAIL b2b_data: got %h want deadbeef", bus2.ReadData); end
    repeat (4) @(negedge Clk);
  endtask

  initial begin
    test_reset;
    test_preload;
    test_write_read;
    test_misalign;
    test_out_of_range;
    test_write_keeps_rdata;
    test_busy_ignore;
    test_reset_mid_write;
    test_wait0;
    test_back_to_back;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
